// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: fetch FSM states, NOP encoding and the IF/ID bundle.
package rv32i_types;

  typedef enum logic [1:0] {
    F_BOOT   = 2'd0,
    F_WAIT   = 2'd1,
    F_HOLD   = 2'd2,
    F_SQUASH = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] WORD_MASK = 32'hffff_fffc;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
  } if_id_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and memory/stall logic (slave).
interface fetch_stage_if;
  // imem_req is a one-cycle strobe that opens a request for imem_addr/imem_rmask;
  // the request stays outstanding until a cycle with imem_resp=1, which carries
  // imem_rdata. The master never raises imem_req again before that response.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_req,
    output imem_addr,
    output imem_rmask,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    input  imem_rmask,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: one-outstanding-request fetch FSM feeding the IF/ID bundle.
// Optional FETCH_INST_BUF_EN holds the last accepted instruction word in a register.
module fetch_stage
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         move,
  input  logic         stop_fetch,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_stage_if.master imem,
  output logic         if_id_valid,
  output logic [31:0]  if_id_pc,
  output logic [31:0]  if_id_pc_next,
  output logic [31:0]  if_id_inst,
  output fetch_state_t dbg_state
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         outstanding;
  logic [31:0]  sq_target;
  logic         req_q;
  logic [31:0]  addr_q;
  logic [3:0]   rmask_q;
  logic         valid_q;
  logic [31:0]  id_pc_q;
  logic [31:0]  id_pc_next_q;
  logic [31:0]  inst_w;
  if_id_t       if_id;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic [31:0] fetch_target;
  logic        resp_hit;
  logic        can_issue;

  assign pc_plus4         = pc + 32'd4;
  assign redirect_aligned = word_align(redirect_pc);
  assign fetch_target     = redirect_valid ? redirect_aligned : pc_plus4;
  assign resp_hit         = imem.imem_resp && outstanding;
  // A response arriving this cycle frees the single slot, so the next fetch may go out.
  assign can_issue        = !outstanding || imem.imem_resp;

  // All progress is gated on move; the stall controller must raise move in the
  // response cycle or the response is not consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= F_BOOT;
      pc           <= RESET_PC;
      outstanding  <= 1'b0;
      sq_target    <= 32'h0;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      rmask_q      <= 4'h0;
      valid_q      <= 1'b0;
      id_pc_q      <= 32'h0;
      id_pc_next_q <= 32'h0;
    end else begin
      req_q <= 1'b0;
      case (state)
        F_BOOT: begin
          req_q       <= 1'b1;
          addr_q      <= RESET_PC;
          rmask_q     <= 4'hf;
          pc          <= RESET_PC;
          outstanding <= 1'b1;
          state       <= F_WAIT;
        end
        F_WAIT: begin
          if (move) begin
            valid_q <= resp_hit;
            if (resp_hit) begin
              id_pc_q      <= pc;
              id_pc_next_q <= pc_plus4;
              outstanding  <= 1'b0;
            end
            if (can_issue) begin
              if (!stop_fetch) begin
                req_q       <= 1'b1;
                addr_q      <= fetch_target;
                pc          <= fetch_target;
                outstanding <= 1'b1;
              end else begin
                state <= F_HOLD;
              end
            end else if (redirect_valid) begin
              sq_target <= redirect_aligned;
              state     <= F_SQUASH;
            end
          end
        end
        F_HOLD: begin
          if (move) begin
            valid_q <= 1'b0;
            if (!stop_fetch) begin
              req_q       <= 1'b1;
              addr_q      <= fetch_target;
              pc          <= fetch_target;
              outstanding <= 1'b1;
              state       <= F_WAIT;
            end
          end
        end
        F_SQUASH: begin
          if (move) begin
            valid_q <= 1'b0;
            if (outstanding) begin
              // The stale response is consumed here and never reaches IF/ID.
              if (imem.imem_resp) outstanding <= 1'b0;
              if (redirect_valid) sq_target <= redirect_aligned;
            end else if (!stop_fetch) begin
              req_q       <= 1'b1;
              addr_q      <= redirect_valid ? redirect_aligned : sq_target;
              pc          <= redirect_valid ? redirect_aligned : sq_target;
              outstanding <= 1'b1;
              state       <= F_WAIT;
            end else if (redirect_valid) begin
              sq_target <= redirect_aligned;
            end
          end
        end
        default: state <= F_BOOT;
      endcase
    end
  end

`ifdef FETCH_INST_BUF_EN
  logic [31:0] inst_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_buf <= NOP_INST;
    end else if (state == F_WAIT && move && resp_hit) begin
      inst_buf <= imem.imem_rdata;
    end
  end

  assign inst_w = inst_buf;
`else
  assign inst_w = imem.imem_resp ? imem.imem_rdata : NOP_INST;
`endif

  always_comb begin
    if_id         = '0;
    if_id.valid   = valid_q;
    if_id.pc      = id_pc_q;
    if_id.pc_next = id_pc_next_q;
    if_id.inst    = inst_w;
  end

  assign imem.imem_req   = req_q;
  assign imem.imem_addr  = addr_q;
  assign imem.imem_rmask = rmask_q;
  assign if_id_valid     = if_id.valid;
  assign if_id_pc        = if_id.pc;
  assign if_id_pc_next   = if_id.pc_next;
  assign if_id_inst      = if_id.inst;
  assign dbg_state       = state;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, sequential fetch, stall, squash, wrap and reset.
module tb_fetch_stage;
  import rv32i_types::*;

  localparam logic [31:0] RST_PC = 32'h1eceb000;

  logic         clk = 1'b0;
  logic         rst;
  logic         move;
  logic         stop_fetch;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         if_id_valid;
  logic [31:0]  if_id_pc;
  logic [31:0]  if_id_pc_next;
  logic [31:0]  if_id_inst;
  fetch_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_buf = NOP_INST;

  fetch_stage_if ifc();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .move           (move),
    .stop_fetch     (stop_fetch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (ifc.master),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_pc_next  (if_id_pc_next),
    .if_id_inst     (if_id_inst),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input fetch_state_t exp);
    chk(tag, {30'b0, dbg_state}, {30'b0, exp});
  endtask

  // instruction expected on if_id_inst in a cycle carrying an accepted response
  function automatic logic [31:0] inst_in_resp(input logic [31:0] rdata);
`ifdef FETCH_INST_BUF_EN
    return exp_buf;
`else
    return rdata;
`endif
  endfunction

  // instruction expected on if_id_inst when imem_resp is low
  function automatic logic [31:0] inst_idle();
`ifdef FETCH_INST_BUF_EN
    return exp_buf;
`else
    return NOP_INST;
`endif
  endfunction

  task automatic expect_issue(input string tag);
    logic [31:0] a;
    chk({tag, "_req"}, {31'b0, ifc.imem_req}, 32'd1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_q: got empty want entry", tag);
    end else begin
      a = exp_q.pop_front();
      chk({tag, "_addr"}, ifc.imem_addr, a);
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_req"}, {31'b0, ifc.imem_req}, 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},     {31'b0, ifc.imem_req}, 32'd0);
    chk({tag, "_rmask"},   {28'b0, ifc.imem_rmask}, 32'h0);
    chk({tag, "_addr"},    ifc.imem_addr, RST_PC);
    chk({tag, "_valid"},   {31'b0, if_id_valid}, 32'd0);
    chk({tag, "_pc"},      if_id_pc, 32'h0);
    chk({tag, "_pc_next"}, if_id_pc_next, 32'h0);
    chk({tag, "_inst"},    if_id_inst, NOP_INST);
    chk_state({tag, "_state"}, F_BOOT);
  endtask

  // drive one accepted response and check the bundle it produces
  task automatic deliver(input string tag, input logic [31:0] rdata, input logic [31:0] pc);
    ifc.imem_resp  = 1'b1;
    ifc.imem_rdata = rdata;
    move           = 1'b1;
    #1;
    chk({tag, "_inst_resp"}, if_id_inst, inst_in_resp(rdata));
    step();
    exp_buf = rdata;
    chk({tag, "_valid"},   {31'b0, if_id_valid}, 32'd1);
    chk({tag, "_pc"},      if_id_pc, pc);
    chk({tag, "_pc_next"}, if_id_pc_next, pc + 32'd4);
  endtask

  initial begin
    rst = 1'b1; move = 1'b0; stop_fetch = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    ifc.imem_resp = 1'b0; ifc.imem_rdata = 32'h0;
    step(); step();
    chk_reset("reset");

    // first post-reset cycle carries a stray response that must be ignored
    rst = 1'b0; move = 1'b1;
    ifc.imem_resp = 1'b1; ifc.imem_rdata = 32'hdeadbeef;
    step();
    exp_q.push_back(RST_PC);
    expect_issue("boot");
    chk("boot_rmask", {28'b0, ifc.imem_rmask}, 32'hf);
    chk("boot_valid", {31'b0, if_id_valid}, 32'd0);
    chk_state("boot_state", F_WAIT);

    exp_q.push_back(RST_PC + 32'd4);
    deliver("first", 32'h00500093, RST_PC);
    expect_issue("first_next");

    // three sequential fetches, each with a stall cycle before the response
    for (int i = 0; i < 3; i++) begin
      ifc.imem_resp = 1'b0; move = 1'b0;
      step();
      expect_idle("seq_gap");
      chk("seq_inst_idle", if_id_inst, inst_idle());
      exp_q.push_back(RST_PC + 32'd8 + 32'(i) * 32'd4);
      deliver("seq", 32'h00100093 + 32'(i), RST_PC + 32'd4 + 32'(i) * 32'd4);
      expect_issue("seq_next");
    end

    // response arrives with stop_fetch: delivered, but no new request
    stop_fetch = 1'b1;
    deliver("stop", 32'h00200113, RST_PC + 32'h10);
    expect_idle("stop_resp");
    chk_state("stop_state", F_HOLD);
    ifc.imem_resp = 1'b0;
    step();
    expect_idle("stop_c1");
    chk("stop_bubble", {31'b0, if_id_valid}, 32'd0);
    step();
    expect_idle("stop_c2");
    move = 1'b0; stop_fetch = 1'b0;
    step();
    expect_idle("freeze");
    chk_state("freeze_state", F_HOLD);
    move = 1'b1;
    step();
    exp_q.push_back(RST_PC + 32'h14);
    expect_issue("release");
    chk_state("release_state", F_WAIT);

    // redirect while the request is outstanding squashes its response
    redirect_valid = 1'b1; redirect_pc = 32'h1eceb100;
    step();
    chk_state("sq_enter", F_SQUASH);
    expect_idle("sq_enter");
    redirect_valid = 1'b0;
    ifc.imem_resp = 1'b1; ifc.imem_rdata = 32'h0badc0de;
    step();
    chk("sq_drop_valid", {31'b0, if_id_valid}, 32'd0);
    expect_idle("sq_drop");
    ifc.imem_resp = 1'b0;
    #1;
    chk("sq_inst", if_id_inst, inst_idle());
    step();
    exp_q.push_back(32'h1eceb100);
    expect_issue("sq_target");
    chk_state("sq_back", F_WAIT);
    exp_q.push_back(32'h1eceb104);
    deliver("sq_resp", 32'h00a00113, 32'h1eceb100);
    expect_issue("sq_resp_next");

    // redirect together with the response: no squash, misaligned target aligned
    redirect_valid = 1'b1; redirect_pc = 32'hffffffff;
    exp_q.push_back(32'hfffffffc);
    deliver("redir_resp", 32'h00000073, 32'h1eceb104);
    expect_issue("redir_resp_next");
    chk_state("redir_resp_state", F_WAIT);
    redirect_valid = 1'b0;

    // top of address space wraps to zero
    exp_q.push_back(32'h0);
    deliver("wrap", 32'h00108093, 32'hfffffffc);
    expect_issue("wrap_next");

    // reset while squashing
    ifc.imem_resp = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h1eceb200;
    step();
    chk_state("rst_sq_state", F_SQUASH);
    rst = 1'b1; redirect_valid = 1'b0; ifc.imem_resp = 1'b1;
    step();
    ifc.imem_resp = 1'b0;
    exp_buf = NOP_INST;
    #1;
    chk_reset("rst_sq");
    rst = 1'b0; ifc.imem_resp = 1'b1; ifc.imem_rdata = 32'hdeadbeef;
    step();
    exp_q.push_back(RST_PC);
    expect_issue("reboot");
    chk("reboot_valid", {31'b0, if_id_valid}, 32'd0);
    chk_state("reboot_state", F_WAIT);
    ifc.imem_resp = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
